zbt_point_arbiter: RTL and testbench

ZBT_POINT_ARBITER -- requirements
Module: zbt_point_arbiter

---
 rtl/zbt_point_arbiter_pkg.sv | 29 ++
 rtl/zbt_point_arbiter_fifo.sv | 51 +++++
 rtl/zbt_point_arbiter.sv | 148 ++++++++++++++
 tb/tb_zbt_point_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zbt_point_arbiter_pkg.sv
// Shared ZBT point-memory definitions for the scanner, the arbiter and the renderer.
// A point word packs x/y/z as three 10-bit fields in the low 30 bits of a 36-bit word.
package zbt_point_arbiter_pkg;

    localparam int ZBT_ADDR_W = 19;
    localparam int ZBT_DATA_W = 36;

    localparam int PT_FIELD_W = 10;
    localparam int PT_X_LSB   = 20;
    localparam int PT_Y_LSB   = 10;
    localparam int PT_Z_LSB   = 0;

    typedef struct packed {
        logic [PT_FIELD_W-1:0] x;
        logic [PT_FIELD_W-1:0] y;
        logic [PT_FIELD_W-1:0] z;
    } point_t;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_READ,
        OP_WRITE
    } zbt_op_e;

    function automatic point_t unpack_point(input logic [ZBT_DATA_W-1:0] word);
        return point_t'(word[PT_X_LSB+PT_FIELD_W-1:PT_Z_LSB]);
    endfunction

endpackage

// File: rtl/zbt_point_arbiter_fifo.sv
// Small synchronous write buffer for scanner points; head word is visible combinationally.
// DEPTH must be a power of two so the wrap bit of the pointers distinguishes full from empty.
module point_wr_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_idx;
    logic [AW:0]      rd_idx;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_idx == rd_idx);
    assign full    = (wr_idx[AW] != rd_idx[AW]) && (wr_idx[AW-1:0] == rd_idx[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_idx[AW-1:0]];

    // NOTE: storage is a handful of flops, so it is cleared with the pointers; a
    // RAM-sized buffer would reset only the pointers and let empty gate the data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_idx[AW-1:0]] <= push_data;
                wr_idx              <= wr_idx + 1'b1;
            end
            if (do_pop) begin
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/zbt_point_arbiter.sv
// Single-port ZBT arbiter: renderer reads have priority, scanner writes are buffered
// and drained in idle slots, with a starvation guard forcing a write after a read streak.
module zbt_point_arbiter
    import zbt_point_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ZBT_ADDR_W,
    parameter int DATA_W       = ZBT_DATA_W,
    parameter int MAX_POINTS   = 524288,
    parameter int STARVE_LIMIT = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              frame_start,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] zbt_addr,
    output logic              zbt_we,
    output logic [DATA_W-1:0] zbt_write_data,
    input  logic [DATA_W-1:0] zbt_read_data,
    output logic [ADDR_W-1:0] point_count,
    output logic              overflow
);

    localparam int                SW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]     GUARD_AT = SW'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(MAX_POINTS - 1);

    zbt_op_e           op;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              push;
    logic              pop;
    logic              wrap;
    logic [SW-1:0]     starve_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] frame_writes;
    logic [2:0]        rd_pipe;

    assign wr_ready = !fifo_full;
    assign push     = wr_valid && wr_ready;
    assign rd_gnt   = (op == OP_READ);
    assign pop      = (op == OP_WRITE);
    assign wrap     = pop && (wr_ptr == LAST_PTR);
    assign rd_valid = rd_pipe[2];

    // NOTE: op gets its default before any condition, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        op = OP_IDLE;
        if (rd_req && (starve_cnt != GUARD_AT)) begin
            op = OP_READ;
        end else if (!fifo_empty) begin
            op = OP_WRITE;
        end
    end

    point_wr_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (wr_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zbt_addr       <= '0;
            zbt_we         <= 1'b0;
            zbt_write_data <= '0;
        end else begin
            case (op)
                OP_READ: begin
                    zbt_addr <= rd_addr;
                    zbt_we   <= 1'b0;
                end
                OP_WRITE: begin
                    zbt_addr       <= wr_ptr;
                    zbt_we         <= 1'b1;
                    zbt_write_data <= fifo_head;
                end
                default: zbt_we <= 1'b0;
            endcase
        end
    end

    // A streak only counts while a write is actually waiting behind it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (pop || fifo_empty) begin
            starve_cnt <= '0;
        end else if (rd_gnt) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // A write coinciding with frame_start lands at the old pointer and still counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            frame_writes <= '0;
            point_count  <= '0;
            overflow     <= 1'b0;
        end else if (frame_start) begin
            wr_ptr       <= '0;
            frame_writes <= '0;
            point_count  <= frame_writes + {{(ADDR_W-1){1'b0}}, pop};
            overflow     <= 1'b0;
        end else begin
            if (pop) begin
                wr_ptr       <= wrap ? '0 : wr_ptr + 1'b1;
                frame_writes <= frame_writes + 1'b1;
            end
            if (wrap) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pipe <= '0;
            rd_data <= '0;
        end else begin
            rd_pipe <= {rd_pipe[1:0], rd_gnt};
            if (rd_pipe[1]) begin
                rd_data <= zbt_read_data;
            end
        end
    end

endmodule

// File: tb/tb_zbt_point_arbiter.sv
// Randomized bench for zbt_point_arbiter against a queue-based model of the arbitration rules.
// Memory reads return a fixed function of the address, registered once to give two-edge latency.
module tb_zbt_point_arbiter;
    import zbt_point_arbiter_pkg::*;

    localparam int AW   = 19;
    localparam int DW   = 36;
    localparam int MAXP = 16;
    localparam int SL   = 8;
    localparam int FD   = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          frame_start;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] zbt_addr;
    logic          zbt_we;
    logic [DW-1:0] zbt_write_data;
    logic [DW-1:0] zbt_read_data;
    logic [AW-1:0] point_count;
    logic          overflow;
    logic [AW-1:0] mem_addr_q;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    zbt_point_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .MAX_POINTS   (MAXP),
        .STARVE_LIMIT (SL),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .frame_start    (frame_start),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_gnt         (rd_gnt),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .zbt_addr       (zbt_addr),
        .zbt_we         (zbt_we),
        .zbt_write_data (zbt_write_data),
        .zbt_read_data  (zbt_read_data),
        .point_count    (point_count),
        .overflow       (overflow)
    );

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        if (a == AW'(5)) return 36'h123456789;
        return {17'h1ABCD ^ a[16:0], a};
    endfunction

    always @(posedge clk) mem_addr_q <= zbt_addr;
    assign zbt_read_data = rom(mem_addr_q);

    // Reference model state
    logic [DW-1:0] m_q[$];
    int            due_q[$];
    int            raddr_q[$];
    int            m_streak;
    int            m_wptr;
    int            m_wcount;
    int            m_point_count;
    bit            m_overflow;
    bit            m_we;
    int            m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rd_data;
    bit            m_rd_valid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        due_q.delete();
        raddr_q.delete();
        m_streak      = 0;
        m_wptr        = 0;
        m_wcount      = 0;
        m_point_count = 0;
        m_overflow    = 0;
        m_we          = 0;
        m_addr        = 0;
        m_wdata       = '0;
        m_rd_data     = '0;
        m_rd_valid    = 0;
    endtask

    task automatic check_regs(input string phase);
        check({phase, " zbt_we"},         64'(zbt_we),         64'(m_we));
        check({phase, " zbt_addr"},       64'(zbt_addr),       64'(m_addr));
        check({phase, " zbt_write_data"}, 64'(zbt_write_data), 64'(m_wdata));
        check({phase, " rd_valid"},       64'(rd_valid),       64'(m_rd_valid));
        check({phase, " rd_data"},        64'(rd_data),        64'(m_rd_data));
        check({phase, " point_count"},    64'(point_count),    64'(m_point_count));
        check({phase, " overflow"},       64'(overflow),       64'(m_overflow));
    endtask

    // One clock: drive at negedge, check combinational outputs, then registered ones after the edge.
    task automatic cycle(input bit rst_v, input bit rq, input int ra, input bit wv,
                         input logic [DW-1:0] wd, input bit fs);
        bit gnt, rdy, wr_op, was_empty, wrap;
        @(negedge clk);
        reset_n     = rst_v;
        rd_req      = rq;
        rd_addr     = AW'(ra);
        wr_valid    = wv;
        wr_data     = wd;
        frame_start = fs;
        #1;
        if (!rst_v) begin
            model_reset();
            check_regs("async_reset");
        end
        gnt       = rq && (m_streak != SL);
        rdy       = (m_q.size() < FD);
        wr_op     = !gnt && (m_q.size() > 0);
        was_empty = (m_q.size() == 0);
        wrap      = wr_op && (m_wptr == MAXP - 1);
        check("rd_gnt", 64'(rd_gnt), 64'(gnt));
        check("wr_ready", 64'(wr_ready), 64'(rdy));
        @(posedge clk);
        #1;
        cyc++;
        if (rst_v) begin
            if (gnt) begin
                m_we   = 0;
                m_addr = ra;
                due_q.push_back(cyc + 2);
                raddr_q.push_back(ra);
            end else if (wr_op) begin
                m_we    = 1;
                m_addr  = m_wptr;
                m_wdata = m_q.pop_front();
            end else begin
                m_we = 0;
            end
            if (wr_op || was_empty) m_streak = 0;
            else if (gnt)           m_streak++;
            if (wr_op) begin
                m_wptr = wrap ? 0 : m_wptr + 1;
                m_wcount++;
            end
            if (wrap) m_overflow = 1;
            if (fs) begin
                m_point_count = m_wcount;
                m_wcount      = 0;
                m_wptr        = 0;
                m_overflow    = 0;
            end
            if (wv && rdy) m_q.push_back(wd);
            m_rd_valid = 0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                m_rd_valid = 1;
                m_rd_data  = rom(AW'(raddr_q[0]));
                void'(due_q.pop_front());
                void'(raddr_q.pop_front());
            end
        end
        check_regs("edge");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, '0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] words[5];
        int            k;
        int            budget;
        model_reset();

        cycle(0, 0, 0, 0, '0, 0);
        cycle(0, 0, 0, 0, '0, 0);

        // Continuous reads of address 5
        for (int i = 0; i < 5; i++) cycle(1, 1, 5, 0, '0, 0);
        idle(4);
        check("read_word_5", 64'(rd_data), 64'(36'h123456789));

        // Three writes with no read traffic
        cycle(1, 0, 0, 1, 36'hA_AAAA_AAAA, 0);
        cycle(1, 0, 0, 1, 36'hB_BBBB_BBBB, 0);
        cycle(1, 0, 0, 1, 36'hC_CCCC_CCCC, 0);
        idle(3);

        // Starvation guard: one word waits behind a read stream
        cycle(1, 1, 7, 1, 36'h5_0000_0001, 0);
        for (int i = 0; i < 14; i++) cycle(1, 1, 8 + i, 0, '0, 0);
        idle(4);

        // Overfill the buffer while reads hog the port
        for (int i = 0; i < 5; i++) words[i] = DW'(36'h7_7000_0000 + i);
        k      = 0;
        budget = 0;
        while (k < 5 && budget < 80) begin
            bit acc;
            acc = (m_q.size() < FD);
            cycle(1, 1, budget, 1, words[k], 0);
            if (acc) k++;
            budget++;
        end
        check("full_fifo_all_pushed", 64'(k), 64'(5));
        for (int i = 0; i < 50; i++) cycle(1, 1, i, 0, '0, 0);
        idle(6);

        // Frame accounting and pointer wrap
        cycle(0, 0, 0, 0, '0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 1, DW'(100 + i), 0);
        idle(2);
        cycle(1, 0, 0, 0, '0, 1);
        check("frame_point_count", 64'(point_count), 64'(10));
        cycle(1, 0, 0, 1, 36'hF_0000_0000, 0);
        idle(1);
        check("first_write_after_frame", 64'(zbt_addr), 64'(0));
        cycle(1, 0, 0, 0, '0, 1);
        for (int i = 0; i < 17; i++) cycle(1, 0, 0, 1, DW'(200 + i), 0);
        idle(1);
        check("overflow_after_17", 64'(overflow), 64'(1));
        check("write17_addr", 64'(zbt_addr), 64'(0));

        // Reset one cycle after a read grant
        cycle(1, 1, 5, 0, '0, 0);
        cycle(0, 0, 0, 0, '0, 0);
        idle(6);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit rst_v;
            rst_v = ($urandom_range(0, 499) != 0);
            cycle(rst_v,
                  ($urandom_range(0, 9) < 7),
                  int'($urandom_range(0, 1023)),
                  ($urandom_range(0, 1) == 1),
                  DW'({$urandom(), $urandom()}),
                  ($urandom_range(0, 39) == 0));
        end
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
